aes128_inv_cipher_iter: RTL

Iterative AES-128 decryption core: ciphertext and key in, plaintext out, one inverse round per clock.
It is the sequential, handshaked receive-side counterpart to the combinational 128-bit encryption path.
It reuses the existing combinational primitives InvShiftRows, InvSubBytes, InvMixColumns, AddRoundKey and KeyExpansion128.
It sits between a ciphertext source and a plaintext sink, both using valid/ready streams.

---
 rtl/aes_pkg.sv | 89 ++++++++
 rtl/aes_inv_round.sv | 43 ++++
 rtl/aes128_inv_cipher_iter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative inverse cipher: sizes, FSM
// state encoding, S-box tables, GF(2^8) helpers, KeyExpansion128 and the
// round-key index helper.
package aes_pkg;

  localparam int NR    = 10;
  localparam int NK    = 4;
  localparam int BLK_W = 128;
  localparam int RK_W  = 128;
  localparam int W_W   = RK_W * (NR + 1);

  typedef enum logic [2:0] {IDLE, KEY, ROUND, FINAL, DONE} state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // multiply by a 4-bit constant (09, 0b, 0d, 0e are all InvMixColumns needs)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  // byte position read by InvShiftRows for output byte k (row r shifted right by r)
  function automatic int inv_shift_src(input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return 4 * ((c - r + 4) % 4) + r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // w[0] is the MSB of the key, so rk[0] == key
  function automatic logic [0:W_W-1] key_expansion128(input logic [RK_W-1:0] key);
    logic [31:0]      w [0:NK*(NR+1)-1];
    logic [31:0]      t;
    logic [0:W_W-1]   o;
    for (int i = 0; i < NK; i++) w[i] = key[RK_W-1-32*i -: 32];
    for (int i = NK; i < NK * (NR + 1); i++) begin
      t = w[i-1];
      if (i % NK == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {RCON_TBL[79 - 8 * (i / NK - 1) -: 8], 24'h0};
      w[i] = w[i-NK] ^ t;
    end
    for (int i = 0; i < NK * (NR + 1); i++) o[32*i +: 32] = w[i];
    return o;
  endfunction

  function automatic logic [RK_W-1:0] rk_sel(input logic [0:W_W-1] w, input int n);
    return w[n*RK_W +: RK_W];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational single AES inverse round:
//   last=0: InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key)
//   last=1: InvSubBytes(InvShiftRows(state)) ^ round_key
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [RK_W-1:0]  round_key,
  input  logic             last,
  output logic [BLK_W-1:0] result
);

  logic [BLK_W-1:0] sr_sb;
  logic [BLK_W-1:0] ak;
  logic [BLK_W-1:0] mc;

  // InvShiftRows folded into the byte select feeding InvSubBytes
  always_comb begin
    sr_sb = '0;
    for (int k = 0; k < 16; k++)
      sr_sb[127-8*k -: 8] = inv_sbox(state[127-8*inv_shift_src(k) -: 8]);
  end

  assign ak = sr_sb ^ round_key;

  // InvMixColumns on each 32-bit column
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 8]    = gmul(ak[127-32*c -: 8], 4'he) ^ gmul(ak[119-32*c -: 8], 4'hb)
                           ^ gmul(ak[111-32*c -: 8], 4'hd) ^ gmul(ak[103-32*c -: 8], 4'h9);
      mc[119-32*c -: 8]    = gmul(ak[127-32*c -: 8], 4'h9) ^ gmul(ak[119-32*c -: 8], 4'he)
                           ^ gmul(ak[111-32*c -: 8], 4'hb) ^ gmul(ak[103-32*c -: 8], 4'hd);
      mc[111-32*c -: 8]    = gmul(ak[127-32*c -: 8], 4'hd) ^ gmul(ak[119-32*c -: 8], 4'h9)
                           ^ gmul(ak[111-32*c -: 8], 4'he) ^ gmul(ak[103-32*c -: 8], 4'hb);
      mc[103-32*c -: 8]    = gmul(ak[127-32*c -: 8], 4'hb) ^ gmul(ak[119-32*c -: 8], 4'hd)
                           ^ gmul(ak[111-32*c -: 8], 4'h9) ^ gmul(ak[103-32*c -: 8], 4'he);
    end
  end

  assign result = last ? ak : mc;

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryption core, one inverse round per clock, with
// valid/ready streams on both sides. Optional macro AES_KEY_CACHE_EN keeps
// the last expanded key and skips expansion when the next key matches.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for ciphertext/key
//   KEY   | expand key into 11 round keys, apply rk[10]
//   ROUND | inverse rounds with rk[9]..rk[1]
//   FINAL | last round (no InvMixColumns) with rk[0] into out_data
//   DONE  | out_valid=1 until out_ready
module aes128_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter bit CLEAR_ON_POP = 1'b1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [RK_W-1:0]  in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data
);

  state_t           st, st_nxt;
  logic [BLK_W-1:0] blk;
  logic [RK_W-1:0]  key_q;
  logic [RK_W-1:0]  rk [0:NR];
  logic [3:0]       cnt;
  logic [0:W_W-1]   w_exp;
  logic [RK_W-1:0]  round_key;
  logic             last_rnd;
  logic [BLK_W-1:0] rnd_out;

  assign w_exp     = key_expansion128(key_q);
  assign round_key = rk[cnt];
  assign last_rnd  = (st == FINAL);

  aes_inv_round u_round (
    .state     (blk),
    .round_key (round_key),
    .last      (last_rnd),
    .result    (rnd_out)
  );

`ifdef AES_KEY_CACHE_EN
  logic [RK_W-1:0] cache_key;
  logic            cache_valid;
  logic            key_hit;

  assign key_hit = cache_valid && (in_key == cache_key);

  // cache tracks the key whose expansion currently sits in rk[]
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_key   <= '0;
    end else if (st == KEY) begin
      cache_valid <= 1'b1;
      cache_key   <= key_q;
    end
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef AES_KEY_CACHE_EN
          st_nxt = key_hit ? ROUND : KEY;
`else
          st_nxt = KEY;
`endif
        end
      end
      KEY:   st_nxt = ROUND;
      ROUND: if (cnt == 4'd1) st_nxt = FINAL;
      FINAL: st_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // datapath: state, key, round keys, counter and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      blk      <= '0;
      key_q    <= '0;
      cnt      <= '0;
      out_data <= '0;
      for (int n = 0; n <= NR; n++) rk[n] <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            blk   <= in_data;
            key_q <= in_key;
`ifdef AES_KEY_CACHE_EN
            if (key_hit) begin
              blk <= in_data ^ rk[NR];
              cnt <= 4'(NR - 1);
            end
`endif
          end
        end
        KEY: begin
          for (int n = 0; n <= NR; n++) rk[n] <= rk_sel(w_exp, n);
          // rk[] is not loaded yet this cycle, so take rk[10] from the expander
          blk <= blk ^ rk_sel(w_exp, NR);
          cnt <= 4'(NR - 1);
        end
        ROUND: begin
          blk <= rnd_out;
          cnt <= cnt - 4'd1;
        end
        FINAL: out_data <= rnd_out;
        DONE: begin
          if (out_ready && CLEAR_ON_POP) out_data <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
